// File: rtl/dic_alarm_ctrl.sv
// Keypad-driven time/alarm setting controller with alarm match detection.
// Every output is registered, so a key sampled on one edge is answered after that edge.
module dic_alarm_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_char,
  input  logic [3:0] di_iMtens,
  input  logic [3:0] di_iMones,
  input  logic [3:0] di_iStens,
  input  logic [3:0] di_iSones,
  input  logic [3:0] di_AMtens,
  input  logic [3:0] di_AMones,
  input  logic [3:0] di_AStens,
  input  logic [3:0] di_ASones,
  input  logic       alarm_state,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic       di_ldAMtens,
  output logic       di_ldAMones,
  output logic       di_ldAStens,
  output logic       di_ldASones,
  output logic [3:0] ld_num,
  output logic       enable_alarm,
  output logic       update_alarm,
  output logic       trigger_alarm,
  output logic       dicRun,
  output logic       dicSelectLEDdisp
);

  localparam logic [7:0] KEY_L   = 8'h4C;
  localparam logic [7:0] KEY_A   = 8'h41;
  localparam logic [7:0] KEY_D   = 8'h44;
  localparam logic [7:0] KEY_N   = 8'h4E;
  localparam logic [7:0] KEY_F   = 8'h46;
  localparam logic [7:0] KEY_S   = 8'h53;
  localparam logic [7:0] KEY_ESC = 8'h1B;

  typedef enum logic [1:0] {IDLE, SET_T, SET_A} state_t;

  state_t     state, stateNext;
  logic [1:0] idx, idxNext;
  logic [3:0] ldT, ldTNext;
  logic [3:0] ldA, ldANext;
  logic [3:0] ldNumNext;
  logic       enableNext, updateNext, selNext, triggerNext;
  logic       prevMatch, match, setTrig, clearTrig;
  logic       isDigit, digitOk;
  logic [3:0] slotOneHot;

  assign match = (di_iMtens == di_AMtens) && (di_iMones == di_AMones) &&
                 (di_iStens == di_AStens) && (di_iSones == di_ASones);

  // Low nibble of ASCII '0'-'9' is the digit value; tens slots (even idx) stop at 5.
  assign isDigit    = (key_char >= 8'h30) && (key_char <= 8'h39);
  assign digitOk    = isDigit && (idx[0] || (key_char[3:0] <= 4'd5));
  assign slotOneHot = 4'b1000 >> idx;

  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    ldTNext    = '0;
    ldANext    = '0;
    ldNumNext  = ld_num;
    enableNext = 1'b0;
    updateNext = update_alarm;
    selNext    = 1'b0;
    clearTrig  = 1'b0;
    if (key_valid) begin
      case (state)
        IDLE: begin
          case (key_char)
            KEY_L: begin stateNext = SET_T; idxNext = '0; end
            KEY_A: begin stateNext = SET_A; idxNext = '0; end
            KEY_D: selNext = 1'b1;
            KEY_N: begin enableNext = 1'b1; updateNext = 1'b1; end
            KEY_F: begin enableNext = 1'b1; updateNext = 1'b0; clearTrig = 1'b1; end
            KEY_S: clearTrig = 1'b1;
            default: ;
          endcase
        end
        SET_T, SET_A: begin
          if (key_char == KEY_ESC) begin
            stateNext = IDLE;
          end else if (digitOk) begin
            if (state == SET_T) ldTNext = slotOneHot;
            else                ldANext = slotOneHot;
            ldNumNext = key_char[3:0];
            idxNext   = idx + 2'd1;
            if (idx == 2'd3) stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end

    // Clear keys take priority over a simultaneous new match.
    setTrig     = match && !prevMatch && alarm_state && (state == IDLE);
    triggerNext = clearTrig ? 1'b0 : (setTrig ? 1'b1 : trigger_alarm);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      idx              <= '0;
      ldT              <= '0;
      ldA              <= '0;
      ld_num           <= '0;
      enable_alarm     <= 1'b0;
      update_alarm     <= 1'b0;
      trigger_alarm    <= 1'b0;
      prevMatch        <= 1'b0;
      dicRun           <= 1'b1;
      dicSelectLEDdisp <= 1'b0;
    end else begin
      state            <= stateNext;
      idx              <= idxNext;
      ldT              <= ldTNext;
      ldA              <= ldANext;
      ld_num           <= ldNumNext;
      enable_alarm     <= enableNext;
      update_alarm     <= updateNext;
      trigger_alarm    <= triggerNext;
      prevMatch        <= match;
      dicRun           <= (stateNext != SET_T);
      dicSelectLEDdisp <= selNext;
    end
  end

  assign ldMtens     = ldT[3];
  assign ldMones     = ldT[2];
  assign ldStens     = ldT[1];
  assign ldSones     = ldT[0];
  assign di_ldAMtens = ldA[3];
  assign di_ldAMones = ldA[2];
  assign di_ldAStens = ldA[1];
  assign di_ldASones = ldA[0];

endmodule

// File: tb/tb_dic_alarm_ctrl.sv
// Directed bench for dic_alarm_ctrl: expected output vectors are queued with each
// stimulus step and checked one clock later against the registered outputs.
module tb_dic_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_char = '0;
  logic [3:0] di_iMtens, di_iMones, di_iStens, di_iSones;
  logic [3:0] di_AMtens, di_AMones, di_AStens, di_ASones;
  logic       alarm_state = 1'b0;
  logic       ldMtens, ldMones, ldStens, ldSones;
  logic       di_ldAMtens, di_ldAMones, di_ldAStens, di_ldASones;
  logic [3:0] ld_num;
  logic       enable_alarm, update_alarm, trigger_alarm, dicRun, dicSelectLEDdisp;

  int total = 0;
  int bad   = 0;

  logic [16:0] expQ[$];
  string       tagQ[$];

  localparam logic [7:0] ESC = 8'h1B;
  // flag order: {enable_alarm, update_alarm, trigger_alarm, dicRun, dicSelectLEDdisp}
  localparam logic [4:0] RUN = 5'b00010;
  localparam logic [4:0] STP = 5'b00000;

  dic_alarm_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_char(key_char),
    .di_iMtens(di_iMtens), .di_iMones(di_iMones), .di_iStens(di_iStens), .di_iSones(di_iSones),
    .di_AMtens(di_AMtens), .di_AMones(di_AMones), .di_AStens(di_AStens), .di_ASones(di_ASones),
    .alarm_state(alarm_state),
    .ldMtens(ldMtens), .ldMones(ldMones), .ldStens(ldStens), .ldSones(ldSones),
    .di_ldAMtens(di_ldAMtens), .di_ldAMones(di_ldAMones),
    .di_ldAStens(di_ldAStens), .di_ldASones(di_ldASones),
    .ld_num(ld_num), .enable_alarm(enable_alarm), .update_alarm(update_alarm),
    .trigger_alarm(trigger_alarm), .dicRun(dicRun), .dicSelectLEDdisp(dicSelectLEDdisp)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic [3:0] t, input logic [3:0] a,
                                     input logic [3:0] n, input logic [4:0] f);
    return {t, a, n, f};
  endfunction

  function automatic logic [16:0] observed();
    return {ldMtens, ldMones, ldStens, ldSones,
            di_ldAMtens, di_ldAMones, di_ldAStens, di_ldASones,
            ld_num, enable_alarm, update_alarm, trigger_alarm, dicRun, dicSelectLEDdisp};
  endfunction

  task automatic checkOut();
    logic [16:0] ex;
    logic [16:0] ob;
    string       tg;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h required=entry", observed());
    end else begin
      ex = expQ.pop_front();
      tg = tagQ.pop_front();
      ob = observed();
      assert (ob === ex) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", tg, ob, ex);
      end
    end
  endtask

  task automatic step(input string tg, input logic kv, input logic [7:0] ch,
                      input logic [16:0] ex);
    @(negedge clk);
    key_valid = kv;
    key_char  = ch;
    expQ.push_back(ex);
    tagQ.push_back(tg);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    checkOut();
  endtask

  task automatic setTime(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    di_iMtens = a; di_iMones = b; di_iStens = c; di_iSones = d;
  endtask

  initial begin
    setTime(4'd1, 4'd2, 4'd3, 4'd4);
    di_AMtens = 4'd0; di_AMones = 4'd0; di_AStens = 4'd0; di_ASones = 4'd5;
    #12;
    expQ.push_back(mk(4'h0, 4'h0, 4'd0, RUN)); tagQ.push_back("reset_state");
    checkOut();
    @(negedge clk);
    rst = 1'b1;

    // Time entry 12:34 style sequence
    step("L_enter",  1'b1, "L", mk(4'h0, 4'h0, 4'd0, STP));
    step("L_dig1",   1'b1, "1", mk(4'h8, 4'h0, 4'd1, STP));
    step("L_dig2",   1'b1, "2", mk(4'h4, 4'h0, 4'd2, STP));
    step("L_dig3",   1'b1, "3", mk(4'h2, 4'h0, 4'd3, STP));
    step("L_dig4",   1'b1, "4", mk(4'h1, 4'h0, 4'd4, RUN));
    step("L_after",  1'b0, 8'h00, mk(4'h0, 4'h0, 4'd4, RUN));

    // IDLE: digits and unknown letters ignored, 'D' pulses
    step("idle_dig", 1'b1, "5", mk(4'h0, 4'h0, 4'd4, RUN));
    step("D1",       1'b1, "D", mk(4'h0, 4'h0, 4'd4, 5'b00011));
    step("D1_off",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd4, RUN));
    step("D2",       1'b1, "D", mk(4'h0, 4'h0, 4'd4, 5'b00011));
    step("D2_off",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd4, RUN));
    step("D3",       1'b1, "D", mk(4'h0, 4'h0, 4'd4, 5'b00011));
    step("idle_X",   1'b1, "X", mk(4'h0, 4'h0, 4'd4, RUN));

    // Alarm entry: illegal tens digit ignored
    step("A_enter",  1'b1, "A", mk(4'h0, 4'h0, 4'd4, RUN));
    step("A_dig6",   1'b1, "6", mk(4'h0, 4'h0, 4'd4, RUN));
    step("A_dig5",   1'b1, "5", mk(4'h0, 4'h8, 4'd5, RUN));
    step("A_X",      1'b1, "X", mk(4'h0, 4'h0, 4'd5, RUN));
    step("A_dig9",   1'b1, "9", mk(4'h0, 4'h4, 4'd9, RUN));
    step("A_esc",    1'b1, ESC, mk(4'h0, 4'h0, 4'd9, RUN));
    step("A_idleD",  1'b1, "D", mk(4'h0, 4'h0, 4'd9, 5'b00011));

    // Abort time entry after one digit
    step("E_enter",  1'b1, "L", mk(4'h0, 4'h0, 4'd9, STP));
    step("E_dig0",   1'b1, "0", mk(4'h8, 4'h0, 4'd0, STP));
    step("E_esc",    1'b1, ESC, mk(4'h0, 4'h0, 4'd0, RUN));
    step("E_idleD",  1'b1, "D", mk(4'h0, 4'h0, 4'd0, 5'b00011));

    // Slot limits: ones accepts 9, seconds tens rejects 6
    step("B_enter",  1'b1, "L", mk(4'h0, 4'h0, 4'd0, STP));
    step("B_dig1",   1'b1, "1", mk(4'h8, 4'h0, 4'd1, STP));
    step("B_dig9",   1'b1, "9", mk(4'h4, 4'h0, 4'd9, STP));
    step("B_dig6",   1'b1, "6", mk(4'h0, 4'h0, 4'd9, STP));
    step("B_dig5",   1'b1, "5", mk(4'h2, 4'h0, 4'd5, STP));
    step("B_dig0",   1'b1, "0", mk(4'h1, 4'h0, 4'd0, RUN));

    // Alarm flag write strobes
    step("N_key",    1'b1, "N", mk(4'h0, 4'h0, 4'd0, 5'b11010));
    step("N_hold",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, 5'b01010));
    step("F_key",    1'b1, "F", mk(4'h0, 4'h0, 4'd0, 5'b10010));
    step("F_hold",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));

    // Alarm match 00:05, armed
    alarm_state = 1'b1;
    setTime(4'd0, 4'd0, 4'd0, 4'd4);
    step("T_0004",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd5);
    step("T_0005",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, 5'b00110));
    step("T_held",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, 5'b00110));
    step("T_S",      1'b1, "S", mk(4'h0, 4'h0, 4'd0, RUN));
    step("T_noretr", 1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd6);
    step("T_0006",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd5);
    step("T_retrig", 1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, 5'b00110));
    step("T_F",      1'b1, "F", mk(4'h0, 4'h0, 4'd0, 5'b10010));
    setTime(4'd0, 4'd0, 4'd0, 4'd6);
    step("C_0006",   1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd5);
    step("C_clrwin", 1'b1, "S", mk(4'h0, 4'h0, 4'd0, RUN));
    step("C_after",  1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd6);
    step("G_A",      1'b1, "A", mk(4'h0, 4'h0, 4'd0, RUN));
    setTime(4'd0, 4'd0, 4'd0, 4'd5);
    step("G_noset",  1'b0, 8'h00, mk(4'h0, 4'h0, 4'd0, RUN));
    step("G_esc",    1'b1, ESC, mk(4'h0, 4'h0, 4'd0, RUN));
    alarm_state = 1'b0;
    setTime(4'd1, 4'd2, 4'd3, 4'd4);

    // Reset mid-load
    step("R_enter",  1'b1, "L", mk(4'h0, 4'h0, 4'd0, STP));
    step("R_dig1",   1'b1, "1", mk(4'h8, 4'h0, 4'd1, STP));
    step("R_dig2",   1'b1, "2", mk(4'h4, 4'h0, 4'd2, STP));
    @(negedge clk);
    rst = 1'b0;
    expQ.push_back(mk(4'h0, 4'h0, 4'd0, RUN)); tagQ.push_back("R_async");
    #1;
    checkOut();
    @(negedge clk);
    rst = 1'b1;
    step("R_dig3",   1'b1, "3", mk(4'h0, 4'h0, 4'd0, RUN));
    step("R_idleD",  1'b1, "D", mk(4'h0, 4'h0, 4'd0, 5'b00011));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dic_alarm_ctrl.md
DIC_ALARM_CTRL -- requirements
Module: dic_alarm_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 key_valid  in  1  one-cycle strobe; key_char valid this cycle.
REQ-004 key_char  in  8  ASCII key code.
REQ-005 di_iMtens/di_iMones/di_iStens/di_iSones  in  4 each  current time digits.
REQ-006 di_AMtens/di_AMones/di_AStens/di_ASones  in  4 each  stored alarm digits.
REQ-007 alarm_state  in  1  stored alarm-armed flag.
REQ-008 ldMtens/ldMones/ldStens/ldSones  out  1 each  time-digit load pulses.
REQ-009 di_ldAMtens/di_ldAMones/di_ldAStens/di_ldASones  out  1 each  alarm-digit load pulses.
REQ-010 ld_num  out  4  digit value accompanying any load pulse.
REQ-011 enable_alarm, update_alarm  out  1 each  alarm-flag write strobe and value.
REQ-012 trigger_alarm  out  1  alarm ringing, level.
REQ-013 dicRun  out  1  1 = clock runs.
REQ-014 dicSelectLEDdisp  out  1  advance LED digit select, one-cycle pulse.

Function
REQ-015 All outputs SHALL be registered; a key accepted in cycle n produces its response in cycle n+1.
REQ-016 FSM states SHALL be IDLE, SET_T, SET_A; a 2-bit digit index idx (0=Mtens, 1=Mones, 2=Stens, 3=Sones) SHALL be used in SET_T and SET_A.
REQ-017 In IDLE: 'L' (0x4C) SHALL go to SET_T with idx=0; 'A' (0x41) SHALL go to SET_A with idx=0.
REQ-018 In IDLE: 'D' (0x44) SHALL pulse dicSelectLEDdisp for 1 cycle.
REQ-019 In IDLE: 'N' (0x4E) SHALL pulse enable_alarm with update_alarm=1.
REQ-020 In IDLE: 'F' (0x46) SHALL pulse enable_alarm with update_alarm=0 and clear trigger_alarm.
REQ-021 In IDLE: 'S' (0x53) SHALL clear trigger_alarm; all other keys SHALL be ignored.
REQ-022 dicRun SHALL be 0 while in SET_T and 1 in IDLE and SET_A.
REQ-023 In SET_T/SET_A, a digit '0'-'9' (0x30-0x39) SHALL be accepted only if legal for the slot: tens slots (idx 0, 2) 0-5, ones slots 0-9.
REQ-024 An accepted digit SHALL pulse exactly one load line for 1 cycle (ld* in SET_T, di_ldA* in SET_A, selected by idx), with ld_num = key_char-0x30, then increment idx.
REQ-025 Illegal digits and non-ESC letters SHALL be ignored in SET_T/SET_A, with no pulse and no idx change.
REQ-026 ESC (0x1B) SHALL abort to IDLE with no load pulse; already-loaded digits SHALL be retained.
REQ-027 Accepting the idx=3 digit SHALL return the FSM to IDLE, with dicRun=1 from the following cycle.
REQ-028 Match SHALL be true when all four time digits equal the alarm digits.
REQ-029 trigger_alarm SHALL set on the rising edge of (match & alarm_state & state==IDLE), using a registered previous-match bit, so a held match does not retrigger after 'S'.
REQ-030 trigger_alarm SHALL remain set until 'S', 'F', or reset.
REQ-031 If a set event and a clear key occur in the same cycle, clear SHALL win.
REQ-032 ld_num SHALL hold its last value when no load pulse is active.

Reset
REQ-033 While rst=0: state=IDLE, idx=0, all pulses=0, ld_num=0, update_alarm=0, trigger_alarm=0, previous-match=0, dicRun=1.
REQ-034 Reset asserted mid-load SHALL abandon the sequence immediately; no further load pulses.

Verification
REQ-035 'L','1','2','3','4' -> ldMtens/ldMones/ldStens/ldSones pulse once each, in order, with ld_num 1,2,3,4; dicRun=0 from the cycle after 'L' until the cycle after '4'.
REQ-036 'A','6' -> no pulse, idx stays 0; then '5' -> di_ldAMtens pulse with ld_num=5.
REQ-037 'L','0',ESC -> one ldMtens pulse (ld_num=0), then IDLE with dicRun=1.
REQ-038 Alarm digits 00:05, 'N', time steps 00:04->00:05 -> trigger_alarm=1 the next cycle; 'S' -> 0; time held at 00:05 -> stays 0.
REQ-039 'D' x3 -> three single-cycle dicSelectLEDdisp pulses; digit keys in IDLE -> no outputs.
REQ-040 rst low during SET_T after 2 digits -> IDLE, dicRun=1, all outputs zero; a following digit key causes no load pulse.
